// File: rtl/dl_reg_rr_arb_if.sv
// dl_reg_rr_arb_if
//   Bundles the requester-side and register-side signals of the shared
//   register round-robin arbiter.
//   Signals:
//     req       requester -> arbiter  per-requester write request
//     req_data  requester -> arbiter  packed write data, requester i at [i*NUM_BITS +: NUM_BITS]
//     req_lock  requester -> arbiter  keep-priority request (lock build only)
//     gnt       arbiter -> requester  one-hot grant (acts as ready)
//     reg_en    arbiter -> register   write enable
//     reg_d     arbiter -> register   write data
//     q         arbiter -> consumers  registered value
//     q_src     arbiter -> consumers  index of the last writer
//     q_vld     arbiter -> consumers  q written at least once since reset
//   Modports: master = requester/consumer side, slave = arbiter.
interface dl_reg_rr_arb_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 32
);
    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*NUM_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]          req_lock;
    logic [NUM_REQ-1:0]          gnt;
    logic                        reg_en;
    logic [NUM_BITS-1:0]         reg_d;
    logic [NUM_BITS-1:0]         q;
    logic [PW-1:0]               q_src;
    logic                        q_vld;

    modport master (
        output req, req_data, req_lock,
        input  gnt, reg_en, reg_d, q, q_src, q_vld
    );

    modport slave (
        input  req, req_data, req_lock,
        output gnt, reg_en, reg_d, q, q_src, q_vld
    );
endinterface

// File: rtl/dl_reg_rr_arb.sv
// dl_reg_rr_arb
//   Round-robin arbiter in front of one shared enable-gated register.
//   Each cycle the first requesting index at or after the rotating pointer
//   is granted; its data is written into the register on the next edge
//   together with the writer index.
//   Optional feature: define DL_REG_RR_ARB_LOCK_EN to let a granted requester
//   holding req_lock keep top priority for up to MAX_LOCK consecutive grants.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   dl_reg_rr_arb_if.slave (req/req_data/req_lock in,
//           gnt/reg_en/reg_d/q/q_src/q_vld out)
module dl_reg_rr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               rst,
    dl_reg_rr_arb_if.slave     bus
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic [PW-1:0]       src_q, src_d;
    logic                vld_q, vld_d;

    logic [PW:0]         scan_idx;
    logic [PW-1:0]       gnt_idx;
    logic                gnt_any;
    logic [NUM_REQ-1:0]  gnt_vec;
    logic [NUM_BITS-1:0] win_data;
    logic [PW-1:0]       rot_ptr;

`ifdef DL_REG_RR_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`else
    // Lock inputs have no effect in this build.
    logic unused_lock;
    assign unused_lock = (^bus.req_lock) ^ MAX_LOCK[0];
`endif

    // Priority scan starting at ptr, wrapping modulo NUM_REQ. Reset masks
    // every grant so nothing reaches the register while rst is high.
    always_comb begin
        scan_idx = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        gnt_vec  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PW+1)'(NUM_REQ);
            end
            if (!gnt_any && !rst && bus.req[scan_idx[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx[PW-1:0];
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        win_data = '0;
        if (gnt_any) begin
            win_data = bus.req_data[gnt_idx*NUM_BITS +: NUM_BITS];
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        vld_d   = vld_q;
        rot_ptr = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef DL_REG_RR_ARB_LOCK_EN
        lock_cnt_d = '0;
`endif
        if (gnt_any) begin
            data_d = win_data;
            src_d  = gnt_idx;
            vld_d  = 1'b1;
`ifdef DL_REG_RR_ARB_LOCK_EN
            // A locked winner keeps the pointer on itself until it has
            // taken MAX_LOCK grants in a row, then has to rotate.
            if (bus.req_lock[gnt_idx] && (lock_cnt_q < LW'(MAX_LOCK - 1))) begin
                ptr_d      = gnt_idx;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                ptr_d      = rot_ptr;
                lock_cnt_d = '0;
            end
`else
            ptr_d = rot_ptr;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            data_q <= '0;
            src_q  <= '0;
            vld_q  <= 1'b0;
`ifdef DL_REG_RR_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            src_q  <= src_d;
            vld_q  <= vld_d;
`ifdef DL_REG_RR_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign bus.gnt    = gnt_vec;
    assign bus.reg_en = gnt_any;
    assign bus.reg_d  = win_data;
    assign bus.q      = data_q;
    assign bus.q_src  = src_q;
    assign bus.q_vld  = vld_q;
endmodule

// File: tb/tb_dl_reg_rr_arb.sv
// tb_dl_reg_rr_arb
//   Directed bench for dl_reg_rr_arb with NUM_REQ=4, NUM_BITS=8, MAX_LOCK=4.
//   Expected register contents are queued when a step is driven and popped
//   after the following clock edge.
module tb_dl_reg_rr_arb;
    logic clk;
    logic rst;

    dl_reg_rr_arb_if #(.NUM_REQ(4), .NUM_BITS(8)) bus ();

    dl_reg_rr_arb #(.NUM_REQ(4), .NUM_BITS(8), .MAX_LOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    exp_t       e;
    logic [7:0] dat[4];
    int         checks;
    int         errors;
    logic [3:0] lock_exp[6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive, check the combinational grant path,
    // queue the register contents expected after the edge, then compare.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] eg, input int pin, input string tag);
        int g;
        g = 0;
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'($urandom);
            if (eg[i]) g = i;
        end
        if (pin >= 0) dat[pin] = 8'hA5;
        rst          = r;
        bus.req      = rq;
        bus.req_lock = lk;
        bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        chk({tag, ":gnt"}, 32'(bus.gnt), 32'(eg));
        chk({tag, ":reg_en"}, 32'(bus.reg_en), 32'(eg != 4'b0));
        if (eg != 4'b0) chk({tag, ":reg_d"}, 32'(bus.reg_d), 32'(dat[g]));
        if (r) begin
            cur.d = 8'h00; cur.s = 2'd0; cur.v = 1'b0;
        end else if (eg != 4'b0) begin
            cur.d = dat[g]; cur.s = 2'(g); cur.v = 1'b1;
        end
        sb.push_back(cur);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s:scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ":q"}, 32'(bus.q), 32'(e.d));
            chk({tag, ":q_src"}, 32'(bus.q_src), 32'(e.s));
            chk({tag, ":q_vld"}, 32'(bus.q_vld), 32'(e.v));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cur.d = 8'h00; cur.s = 2'd0; cur.v = 1'b0;
`ifdef DL_REG_RR_ARB_LOCK_EN
        lock_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
        lock_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_lock = '0;
        bus.req_data = '0;
        @(posedge clk);
        #1;

        // Reset holds grants off even with requests present.
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, -1, "rst_req");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, -1, "rst");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, "idle");

        // Single request from requester 2 with data 0xA5; pointer moves to 3.
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 2, "single");
        // Grant 3 so the pointer wraps to 0 before the fairness run.
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, -1, "pre3");

        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'(1 << (k % 4)), -1, "rr");
        end

        // Pointer at 0 after the grant to 3.
        step(1'b0, 4'b1001, 4'b0000, 4'b0001, -1, "wrap0");
        step(1'b0, 4'b1001, 4'b0000, 4'b1000, -1, "wrap3");

        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'b0011, 4'b0001, lock_exp[k], -1, "lock");
        end

        // Single requester held: granted every cycle, pointer wraps at 3.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b1000, 4'b0000, 4'b1000, -1, "hold3");
        end

        step(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, "drop");
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, -1, "g1");

        // Reset beats a simultaneous request; afterwards scanning starts at 0.
        step(1'b1, 4'b0010, 4'b0000, 4'b0000, -1, "rst_pri");
        step(1'b0, 4'b1111, 4'b0000, 4'b0001, -1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
